soc_system_control_sequencer: RTL and testbench

//  Consumer of the 4x8 dual-port control RAM: drives the FPGA-side port (s2) as a simple master.

---
 rtl/soc_system_control_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_soc_system_control_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_control_sequencer.sv
// ----------------------------------------------------------------------------
// soc_system_control_sequencer
//
// Purpose:
//   Drives the FPGA-side port (s2) of the 4x8 dual-port control RAM as a
//   simple master. It polls the CMD byte that the HPS writes and launches the
//   AES core once per block. It then writes the result count and STATUS back,
//   and clears CMD so the HPS can see that the job has finished.
//
//   RAM map: 0 CMD (bit0 start, bit1 mode), 1 STATUS (bit0 busy, bit1 done,
//            bit2 error), 2 block count N, 3 result count.
//
// Ports:
//   clk, reset_n        single clock, asynchronous active-low reset
//   enable              0 holds the sequencer in IDLE and stops polling
//   ctrl_address..      RAM port-2 master signals (address, chipselect, write,
//   ctrl_clken          writedata, clken). The read data is valid one cycle
//   ctrl_readdata       after the address is presented.
//   core_start          one-cycle launch pulse per block
//   core_mode           0 = encrypt, 1 = decrypt (latched from CMD[1])
//   core_done           one-cycle completion pulse from the AES core
//   busy                high while a job is in progress
//   blocks_done         blocks completed in the current or the last job
//
// Core handshake: core_start is a single-cycle request pulse and has no ready.
//   The core answers each pulse with exactly one core_done pulse. A core_done
//   pulse counts only while the sequencer waits in WAIT_CORE. Every other
//   core_done pulse is ignored, including one in the launch cycle.
//
// Configuration:
//   SOC_CTRL_SEQ_WATCHDOG_EN  When defined, adds a 16-bit core_done watchdog.
//                             After TIMEOUT_CYCLES cycles in WAIT_CORE the job
//                             is aborted and STATUS reports an error (0x04).
// ----------------------------------------------------------------------------
module soc_system_control_sequencer #(
    parameter int unsigned POLL_INTERVAL  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic [1:0] ctrl_address,
    output logic       ctrl_chipselect,
    output logic       ctrl_write,
    output logic [7:0] ctrl_writedata,
    output logic       ctrl_clken,
    input  logic [7:0] ctrl_readdata,
    output logic       core_start,
    output logic       core_mode,
    input  logic       core_done,
    output logic       busy,
    output logic [7:0] blocks_done
);

    localparam int unsigned PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);
    localparam logic [15:0]   WD_LIMIT    = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_RD_CMD    = 4'd1;
    localparam logic [3:0] S_CHK_CMD   = 4'd2;
    localparam logic [3:0] S_RD_CNT    = 4'd3;
    localparam logic [3:0] S_CHK_CNT   = 4'd4;
    localparam logic [3:0] S_WR_BUSY   = 4'd5;
    localparam logic [3:0] S_LAUNCH    = 4'd6;
    localparam logic [3:0] S_WAIT_CORE = 4'd7;
    localparam logic [3:0] S_WR_RES    = 4'd8;
    localparam logic [3:0] S_WR_STAT   = 4'd9;
    localparam logic [3:0] S_CLR_CMD   = 4'd10;

    logic [3:0]    state_q, state_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic [7:0]    blocks_q, blocks_d;
    logic [7:0]    n_q, n_d;

    logic wd_expired;  // watchdog fires this cycle (WAIT_CORE, no core_done)
    logic err_flag;    // current job was aborted by the watchdog

`ifdef SOC_CTRL_SEQ_WATCHDOG_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        err_q, err_d;

    assign wd_expired = (state_q == S_WAIT_CORE) && !core_done && (wd_cnt_q == WD_LIMIT);
    assign err_flag   = err_q;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        err_d    = err_q;
        if (state_q == S_CHK_CMD && ctrl_readdata[0]) begin
            err_d = 1'b0;
        end
        // LAUNCH always precedes WAIT_CORE, so clearing here restarts the
        // count on every entry to WAIT_CORE.
        if (state_q == S_LAUNCH) begin
            wd_cnt_d = '0;
        end else if (state_q == S_WAIT_CORE && !core_done && !wd_expired) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
        if (wd_expired) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    // Without the watchdog, WAIT_CORE waits for core_done indefinitely.
    logic unused_timeout;
    assign wd_expired     = 1'b0;
    assign err_flag       = 1'b0;
    assign unused_timeout = ^WD_LIMIT;
`endif

    always_comb begin
        state_d         = state_q;
        poll_cnt_d      = poll_cnt_q;
        mode_d          = mode_q;
        busy_d          = busy_q;
        blocks_d        = blocks_q;
        n_d             = n_q;
        ctrl_address    = 2'd0;
        ctrl_chipselect = 1'b0;
        ctrl_write      = 1'b0;
        ctrl_writedata  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (poll_cnt_q == '0) begin
                        state_d = S_RD_CMD;
                    end else begin
                        poll_cnt_d = poll_cnt_q - PW'(1);
                    end
                end
            end
            S_RD_CMD: begin
                ctrl_address    = ADDR_CMD;
                ctrl_chipselect = 1'b1;
                state_d         = S_CHK_CMD;
            end
            S_CHK_CMD: begin
                if (ctrl_readdata[0]) begin
                    mode_d   = ctrl_readdata[1];
                    busy_d   = 1'b1;
                    blocks_d = 8'd0;
                    state_d  = S_RD_CNT;
                end else begin
                    poll_cnt_d = POLL_RELOAD;
                    state_d    = S_IDLE;
                end
            end
            S_RD_CNT: begin
                ctrl_address    = ADDR_COUNT;
                ctrl_chipselect = 1'b1;
                state_d         = S_CHK_CNT;
            end
            S_CHK_CNT: begin
                n_d     = ctrl_readdata;
                state_d = S_WR_BUSY;
            end
            S_WR_BUSY: begin
                ctrl_address    = ADDR_STATUS;
                ctrl_chipselect = 1'b1;
                ctrl_write      = 1'b1;
                ctrl_writedata  = 8'h01;
                // An empty job skips the core and reports done with a zero count.
                state_d         = (n_q == 8'd0) ? S_WR_RES : S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    blocks_d = blocks_q + 8'd1;
                    state_d  = (blocks_q + 8'd1 == n_q) ? S_WR_RES : S_LAUNCH;
                end else if (wd_expired) begin
                    state_d = S_WR_RES;
                end
            end
            S_WR_RES: begin
                ctrl_address    = ADDR_RESULT;
                ctrl_chipselect = 1'b1;
                ctrl_write      = 1'b1;
                ctrl_writedata  = blocks_q;
                state_d         = S_WR_STAT;
            end
            S_WR_STAT: begin
                ctrl_address    = ADDR_STATUS;
                ctrl_chipselect = 1'b1;
                ctrl_write      = 1'b1;
                ctrl_writedata  = err_flag ? 8'h04 : 8'h02;
                state_d         = S_CLR_CMD;
            end
            S_CLR_CMD: begin
                ctrl_address    = ADDR_CMD;
                ctrl_chipselect = 1'b1;
                ctrl_write      = 1'b1;
                ctrl_writedata  = 8'h00;
                busy_d          = 1'b0;
                poll_cnt_d      = POLL_RELOAD;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            poll_cnt_q <= POLL_RELOAD;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            blocks_q   <= 8'd0;
            n_q        <= 8'd0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            blocks_q   <= blocks_d;
            n_q        <= n_d;
        end
    end

    // core_start and the bus signals decode directly from state_q. Because
    // state_q resets asynchronously, they drop in the same cycle as reset_n.
    assign core_start  = (state_q == S_LAUNCH);
    assign core_mode   = mode_q;
    assign busy        = busy_q;
    assign blocks_done = blocks_q;
    assign ctrl_clken  = 1'b1;

endmodule

// File: tb/tb_soc_system_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_soc_system_control_sequencer
//
// Bench for soc_system_control_sequencer. It contains a behavioural model of
// the control RAM (one-cycle read latency), a model of the AES core that
// answers each start with a done pulse after a set number of cycles, and an
// HPS-side driver. Expected RAM write sequences are built from the job rules
// into exp_q and compared against the writes the DUT actually makes.
// ----------------------------------------------------------------------------
module tb_soc_system_control_sequencer;

    localparam int P  = 16;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] ctrl_address;
    logic       ctrl_chipselect;
    logic       ctrl_write;
    logic [7:0] ctrl_writedata;
    logic       ctrl_clken;
    logic [7:0] ctrl_readdata;
    logic       core_start;
    logic       core_mode;
    logic       core_done;
    logic       busy;
    logic [7:0] blocks_done;

    soc_system_control_sequencer #(
        .POLL_INTERVAL (P),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .ctrl_address   (ctrl_address),
        .ctrl_chipselect(ctrl_chipselect),
        .ctrl_write     (ctrl_write),
        .ctrl_writedata (ctrl_writedata),
        .ctrl_clken     (ctrl_clken),
        .ctrl_readdata  (ctrl_readdata),
        .core_start     (core_start),
        .core_mode      (core_mode),
        .core_done      (core_done),
        .busy           (busy),
        .blocks_done    (blocks_done)
    );

    // ---------------- control RAM model + bus logs ----------------
    logic [7:0] mem [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] rd_data   = 8'h00;
    logic       hps_we    = 1'b0;
    logic [1:0] hps_addr  = 2'd0;
    logic [7:0] hps_data  = 8'h00;
    logic [9:0] wr_log      [0:2047];
    int         rd_cyc      [0:2047];
    logic [1:0] rd_addr_log [0:2047];
    int         wr_total = 0;
    int         rd_total = 0;
    int         cyc      = 0;

    assign ctrl_readdata = rd_data;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (hps_we) mem[hps_addr] <= hps_data;
        if (ctrl_chipselect) begin
            if (ctrl_write) begin
                mem[ctrl_address] <= ctrl_writedata;
                wr_log[wr_total]  <= {ctrl_address, ctrl_writedata};
                wr_total          <= wr_total + 1;
            end else begin
                rd_data               <= mem[ctrl_address];
                rd_cyc[rd_total]      <= cyc;
                rd_addr_log[rd_total] <= ctrl_address;
                rd_total              <= rd_total + 1;
            end
        end
    end

    // ---------------- AES core model ----------------
    int   done_delay      = 5;   // 0 = never answer
    int   cd_cnt          = 0;
    int   starts_total    = 0;
    logic core_done_auto  = 1'b0;
    logic core_done_force = 1'b0;

    assign core_done = core_done_auto | core_done_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cd_cnt         <= 0;
            core_done_auto <= 1'b0;
        end else begin
            core_done_auto <= 1'b0;
            if (core_start) begin
                starts_total <= starts_total + 1;
                cd_cnt       <= done_delay;
            end else if (cd_cnt != 0) begin
                cd_cnt <= cd_cnt - 1;
                if (cd_cnt == 1) core_done_auto <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];

    // Reference state: what the HPS would observe after each job.
    logic       m_mode   = 1'b0;
    logic [7:0] m_blocks = 8'd0;
    logic [7:0] m_res    = 8'd0;
    logic [7:0] m_stat   = 8'd0;
    logic [7:0] m_cmd    = 8'd0;
    int         m_starts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job rules: a CMD with bit0 set runs N blocks. Each block produces one
    // start. The RAM sees STATUS=busy, then the result, then STATUS=done, then
    // CMD cleared. Any other CMD is left alone.
    function automatic void model_job(input logic [7:0] cmd, input logic [7:0] n);
        if (cmd[0]) begin
            exp_q.push_back({2'd1, 8'h01});
            exp_q.push_back({2'd3, n});
            exp_q.push_back({2'd1, 8'h02});
            exp_q.push_back({2'd0, 8'h00});
            m_starts = int'(n);
            m_mode   = cmd[1];
            m_blocks = n;
            m_res    = n;
            m_stat   = 8'h02;
            m_cmd    = 8'h00;
        end else begin
            m_starts = 0;
            m_cmd    = cmd;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic hps_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        hps_addr = a;
        hps_data = d;
        hps_we   = 1'b1;
        @(negedge clk);
        hps_we   = 1'b0;
    endtask

    // Posts a job (unless skip_hps) and waits for it to complete. With
    // launch_hit set, a core_done pulse is injected during the first launch
    // cycle. The DUT's writes are compared against exp_q.
    task automatic run_case(input logic [7:0] cmd, input logic [7:0] n, input int delay,
                            input bit launch_hit, input bit skip_hps, output int starts);
        int w0, s0, budget;
        bit seen_busy, finished, hit, force_on;
        logic [9:0] e;
        done_delay = delay;
        w0 = wr_total;
        s0 = starts_total;
        if (!skip_hps) begin
            hps_write(2'd2, n);
            hps_write(2'd0, cmd);
        end
        seen_busy = 0; finished = 0; hit = 0; force_on = 0;
        if (cmd[0]) begin
            budget = 120 + int'(n) * (delay + 8);
            for (int i = 0; i < budget && !finished; i++) begin
                @(negedge clk);
                if (force_on) begin
                    core_done_force = 1'b0;
                    force_on = 0;
                    check("launch_done_ignored", blocks_done, 0);
                end
                if (launch_hit && !hit && core_start) begin
                    core_done_force = 1'b1;
                    hit = 1;
                    force_on = 1;
                end
                if (busy) seen_busy = 1;
                if (wr_total - w0 >= 4 && !busy) finished = 1;
            end
            core_done_force = 1'b0;
            check("job_complete", finished, 1);
            check("busy_seen", seen_busy, 1);
            repeat (3) @(negedge clk);
        end else begin
            repeat (3 * (P + 2) + 4) @(negedge clk);
        end
        starts = starts_total - s0;
        check("write_count", wr_total - w0, exp_q.size());
        for (int i = w0; i < wr_total; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3ff;
            check("write_seq", wr_log[i], e);
        end
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] cmd;
        logic [7:0] n;
        int         delay;
        int         exp_starts;
        logic [7:0] exp_res;
        logic [7:0] exp_stat;
        logic       exp_mode;
        logic [7:0] exp_blocks;
        logic [7:0] exp_cmd;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        int r0, w0, s0, got;
        logic [7:0] rc, rn;
        int rd;

        vecs[0] = '{8'h01, 8'd3, 5,  3, 8'h03, 8'h02, 1'b0, 8'd3, 8'h00};
        vecs[1] = '{8'h03, 8'd0, 1,  0, 8'h00, 8'h02, 1'b1, 8'd0, 8'h00};
        vecs[2] = '{8'h00, 8'd4, 2,  0, 8'h00, 8'h02, 1'b1, 8'd0, 8'h00};
        vecs[3] = '{8'h03, 8'd1, 1,  1, 8'h01, 8'h02, 1'b1, 8'd1, 8'h00};
        vecs[4] = '{8'h02, 8'd5, 1,  0, 8'h01, 8'h02, 1'b1, 8'd1, 8'h02};
        vecs[5] = '{8'h01, 8'd2, 12, 2, 8'h02, 8'h02, 1'b0, 8'd2, 8'h00};

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_clken", ctrl_clken, 1);
        check("rst_cs", ctrl_chipselect, 0);
        check("rst_write", ctrl_write, 0);
        check("rst_start", core_start, 0);
        check("rst_mode", core_mode, 0);
        check("rst_busy", busy, 0);
        check("rst_blocks", blocks_done, 0);
        reset_n = 1'b1;

        // ---- enable=0 holds IDLE: no bus traffic ----
        r0 = rd_total;
        repeat (50) @(negedge clk);
        check("disabled_no_reads", rd_total - r0, 0);

        // ---- idle polling with CMD=0 ----
        enable = 1'b1;
        repeat (P + 2) @(negedge clk);
        r0 = rd_total; w0 = wr_total; s0 = starts_total;
        repeat (5 * (P + 2)) @(negedge clk);
        check("poll_read_count", rd_total - r0, 5);
        for (int i = r0 + 1; i < rd_total; i++) begin
            check("poll_interval", rd_cyc[i] - rd_cyc[i-1], P + 2);
            check("poll_addr", rd_addr_log[i], 0);
        end
        check("poll_no_writes", wr_total - w0, 0);
        check("poll_no_starts", starts_total - s0, 0);

        // ---- table-driven jobs ----
        for (int v = 0; v < 6; v++) begin
            model_job(vecs[v].cmd, vecs[v].n);
            run_case(vecs[v].cmd, vecs[v].n, vecs[v].delay, 1'b0, 1'b0, got);
            check("tbl_starts", got, vecs[v].exp_starts);
            check("tbl_result", mem[3], vecs[v].exp_res);
            check("tbl_status", mem[1], vecs[v].exp_stat);
            check("tbl_cmd", mem[0], vecs[v].exp_cmd);
            check("tbl_mode", core_mode, vecs[v].exp_mode);
            check("tbl_blocks", blocks_done, vecs[v].exp_blocks);
            check("tbl_busy_low", busy, 0);
        end

        // ---- spurious core_done in IDLE, then a done on the launch cycle ----
        wait (!busy);
        @(negedge clk); core_done_force = 1'b1;
        @(negedge clk); core_done_force = 1'b0;
        check("spurious_idle_blocks", blocks_done, m_blocks);
        check("spurious_idle_busy", busy, 0);
        model_job(8'h01, 8'd2);
        run_case(8'h01, 8'd2, 4, 1'b1, 1'b0, got);
        check("launch_hit_starts", got, 2);
        check("launch_hit_blocks", blocks_done, 2);
        check("launch_hit_result", mem[3], 8'h02);

        // ---- reset in WAIT_CORE of an N=2 job ----
        done_delay = 30;
        hps_write(2'd2, 8'd2);
        hps_write(2'd0, 8'h01);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (core_start) seen = 1;
            end
            check("midjob_started", seen, 1);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_start", core_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_blocks", blocks_done, 0);
        check("midrst_mode", core_mode, 0);
        check("midrst_cs", ctrl_chipselect, 0);
        check("midrst_clken", ctrl_clken, 1);
        check("midrst_cmd_kept", mem[0], 8'h01);
        check("midrst_status_kept", mem[1], 8'h01);
        m_blocks = 8'd0;
        m_mode   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_job(8'h01, 8'd2);
        run_case(8'h01, 8'd2, 3, 1'b0, 1'b1, got);
        check("restart_starts", got, 2);
        check("restart_blocks", blocks_done, 2);
        check("restart_status", mem[1], 8'h02);
        check("restart_cmd", mem[0], 8'h00);

        // ---- randomized jobs against the reference model ----
        for (int k = 0; k < 10; k++) begin
            rc = 8'($urandom_range(0, 3));
            rn = 8'($urandom_range(0, 6));
            rd = $urandom_range(1, 6);
            model_job(rc, rn);
            run_case(rc, rn, rd, 1'b0, 1'b0, got);
            check("rnd_starts", got, m_starts);
            check("rnd_result", mem[3], m_res);
            check("rnd_status", mem[1], m_stat);
            check("rnd_cmd", mem[0], m_cmd);
            check("rnd_mode", core_mode, m_mode);
            check("rnd_blocks", blocks_done, m_blocks);
            check("rnd_busy_low", busy, 0);
        end

`ifdef SOC_CTRL_SEQ_WATCHDOG_EN
        // ---- watchdog: the core never answers ----
        exp_q.push_back({2'd1, 8'h01});
        exp_q.push_back({2'd3, 8'h00});
        exp_q.push_back({2'd1, 8'h04});
        exp_q.push_back({2'd0, 8'h00});
        run_case(8'h01, 8'd1, 0, 1'b0, 1'b0, got);
        check("wd_starts", got, 1);
        check("wd_status", mem[1], 8'h04);
        check("wd_result", mem[3], 8'h00);
        check("wd_blocks", blocks_done, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
